// File: rtl/const_div_pkg.sv
// Shared types and elaboration helpers for the digit-serial constant divider.
package const_div_pkg;

  // Sequencer states: waiting for a dividend, consuming digits, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MIN_DIVISOR = 2;
  localparam int MAX_DIVISOR = 255;
  localparam int MAX_DIGIT   = 8;

  // Remainder width: just enough bits to hold DIVISOR-1.
  function automatic int clog2_div(input int divisor);
    return $clog2(divisor);
  endfunction

  // Legal parameter set: whole number of digits, divisor in the supported range.
  function automatic bit cfg_ok(input int width, input int divisor, input int digit);
    return (digit >= 1) && (digit <= MAX_DIGIT) && (width >= digit) &&
           (width % digit == 0) &&
           (divisor >= MIN_DIVISOR) && (divisor <= MAX_DIVISOR);
  endfunction

endpackage

// File: rtl/const_div_digit.sv
// One digit step of long division by a constant: {r, d} -> (quotient digit, new remainder).
// Purely combinational; the whole step is a constant lookup table addressed by {r, d}.
module const_div_digit
  import const_div_pkg::*;
#(
  parameter int  DIVISOR = 3,
  parameter int  DIGIT   = 4,
  localparam int RW      = clog2_div(DIVISOR)
) (
  input  logic [RW-1:0]    r,
  input  logic [DIGIT-1:0] d,
  output logic [DIGIT-1:0] q_d,
  output logic [RW-1:0]    r_next
);

  localparam int TW    = RW + DIGIT;
  localparam int DEPTH = 1 << TW;

  // Table content for address t. Because r < DIVISOR, t < DIVISOR*2^DIGIT and the
  // quotient digit always fits DIGIT bits; addresses with r >= DIVISOR never occur.
  function automatic logic [TW-1:0] table_entry(input int unsigned t);
    int unsigned q;
    int unsigned m;
    q = t / DIVISOR;
    m = t % DIVISOR;
    return {q[DIGIT-1:0], m[RW-1:0]};
  endfunction

  logic [TW-1:0] w_table [DEPTH];
  logic [TW-1:0] w_addr;
  logic [TW-1:0] w_entry;

  for (genvar a = 0; a < DEPTH; a++) begin : g_table
    assign w_table[a] = table_entry(a);
  end

  assign w_addr  = {r, d};
  assign w_entry = w_table[w_addr];
  assign q_d     = w_entry[TW-1:RW];
  assign r_next  = w_entry[RW-1:0];

endmodule

// File: rtl/const_div_serial.sv
// Digit-serial divider by a compile-time constant. Consumes DIGIT dividend bits per
// cycle, MSB first, carrying the partial remainder; result is held until accepted.
module const_div_serial
  import const_div_pkg::*;
#(
  parameter int  WIDTH   = 64,
  parameter int  DIVISOR = 3,
  parameter int  DIGIT   = 4,
  localparam int RW      = clog2_div(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [RW-1:0]    remainder
);

  localparam int             N    = WIDTH / DIGIT;
  localparam int             CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  if (!cfg_ok(WIDTH, DIVISOR, DIGIT)) begin : g_bad_cfg
    $error("const_div_serial: WIDTH must be a multiple of DIGIT (1..8), DIVISOR 2..255");
  end

  state_e           r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_quot;
  logic [RW-1:0]    r_rem;

  logic [DIGIT-1:0] w_digit;
  logic [DIGIT-1:0] w_q_d;
  logic [RW-1:0]    w_r_next;

  assign w_digit = r_shift[WIDTH-1 -: DIGIT];

  const_div_digit #(
    .DIVISOR (DIVISOR),
    .DIGIT   (DIGIT)
  ) u_digit (
    .r      (r_rem),
    .d      (w_digit),
    .q_d    (w_q_d),
    .r_next (w_r_next)
  );

  // Sequencer and datapath: load on accept, one digit per BUSY cycle, hold in DONE.
  // NOTE: every register here uses <= so all of them update from the same pre-edge values;
  // the datapath registers are reset as well because quotient/remainder are visible outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_shift <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift <= dividend;
            r_quot  <= '0;
            r_rem   <= '0;
            r_count <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_shift <= r_shift << DIGIT;
          r_quot  <= (r_quot << DIGIT) | WIDTH'(w_q_d);
          r_rem   <= w_r_next;
          r_count <= r_count + 1'b1;
          if (r_count == LAST) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake flags decode registered state only, so no input-to-output path exists.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign quotient  = r_quot;
  assign remainder = r_rem;

endmodule

// File: doc/const_div_serial.md
# const_div_serial

Parametrised, digit-serial constant divider that computes the quotient and remainder of a WIDTH-bit unsigned dividend by a compile-time constant DIVISOR. It processes DIGIT bits per cycle, MSB first, and carries the partial remainder between cycles. This is the sequential, generalised successor to the fixed divide-by-3 combinational quotient slices. It sits behind a valid/ready source and in front of a valid/ready sink in the constant-division datapath.

## Interface
- WIDTH, default 64: dividend and quotient width. Must be a multiple of DIGIT.
- DIVISOR, default 3: constant divisor, integer, 2..255.
- DIGIT, default 4: dividend bits consumed per cycle, 1..8.
- Derived RW = $clog2(DIVISOR): remainder width.
- Derived N = WIDTH/DIGIT: digit count.
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  dividend offered.
- in_ready  out  1  block can accept a dividend.
- dividend  in  WIDTH  unsigned dividend; sampled only on the input handshake.
- out_valid  out  1  result available.
- out_ready  in  1  sink accepts the result.
- quotient  out  WIDTH  floor(dividend / DIVISOR).
- remainder  out  RW  dividend mod DIVISOR.

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, quotient=0, remainder=0, digit counter=0.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from registered state, with no combinational path from inputs.
- IDLE, on in_valid&&in_ready:
  - load dividend into the shift register, clear the partial remainder r to 0 and the counter to 0;
  - go to BUSY.
- BUSY, each cycle:
  - t = {r, top DIGIT bits of the shift register};
  - q_d = t / DIVISOR, r_next = t % DIVISOR;
  - shift q_d into the LSBs of the quotient register and shift the dividend register left by DIGIT;
  - counter++.
- BUSY exit: when counter==N-1 on the current edge, go to DONE.
- DONE: quotient, remainder and out_valid are held stable until out_ready=1. On out_valid&&out_ready, go to IDLE.
- Width rules:
  - t is RW+DIGIT bits;
  - t < DIVISOR*2^DIGIT, so q_d always fits in DIGIT bits;
  - r_next < DIVISOR always;
  - no overflow path exists.
- in_valid while not IDLE is ignored. The source must hold the dividend until in_ready.
- out_ready outside DONE has no effect.
- DIVISOR a power of two is legal; the result is an exact shift and mask.
- Asynchronous reset asserted mid-operation (BUSY or DONE):
  - immediately returns to IDLE with the reset values;
  - the in-flight result is discarded, never emitted.

## Timing
- Input handshake at edge E0, then BUSY for N edges. out_valid is high after edge E0+N, giving latency N cycles (16 for the defaults).
- Minimum initiation interval is N+2 cycles: accept, N digits, output handshake, back to IDLE.
- Critical path is one table lookup of RW+DIGIT address bits plus the shift mux. It must meet timing at DIGIT=4, DIVISOR≤15 on the target FPGA (6-input LUT plus a register).

## Structure
- Package const_div_pkg holds:
  - the state enum (IDLE/BUSY/DONE);
  - the function clog2_div(DIVISOR);
  - an elaboration-time check function that WIDTH%DIGIT==0 and 2≤DIVISOR≤255.
- Sub-module const_div_digit is purely combinational. Inputs: r[RW], d[DIGIT]. Outputs: q_d[DIGIT], r_next[RW]. It is generated as a constant table with DIVISOR and DIGIT as parameters, and is reusable by a future unrolled version.
- Top level: the FSM, counter, dividend and quotient shift registers, and the remainder register.

## Test plan
- WIDTH=64, DIVISOR=3, DIGIT=4; dividend 0xFFFF_FFFF_FFFF_FFFF -> quotient 0x5555_5555_5555_5555, remainder 0, out_valid 16 cycles after the handshake.
- Defaults; dividend 100 -> quotient 0x21, remainder 1. Dividend 0 -> quotient 0, remainder 0.
- WIDTH=16, DIVISOR=7, DIGIT=4; dividend 0xFFFF -> quotient 0x2492, remainder 1, latency 4.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - quotient, remainder and out_valid are stable; in_ready=0; a new in_valid is ignored.
  - Release out_ready -> IDLE the next cycle.
- Pull rst_n low at BUSY cycle 7:
  - outputs return to their reset values at once;
  - no out_valid follows;
  - the next dividend, 9 -> quotient 3, remainder 0.
- Randomised test over 10k dividends and DIVISOR ∈ {3,5,7,10,255}, DIGIT ∈ {1,3,4,8}: results match a reference model of / and %, with random in_valid/out_ready stalls.
